// File: rtl/ysyx_24090003_mdu_pkg.sv
// rtl/ysyx_24090003_mdu_pkg.sv - shared op encodings and FSM states for the multiply-divide unit
package ysyx_24090003_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/ysyx_24090003_mdu.sv
// rtl/ysyx_24090003_mdu.sv - iterative radix-2 RV32M/RV64M multiply-divide unit
module ysyx_24090003_mdu
    import ysyx_24090003_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg1_q, neg2_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc;

    logic              accept;
    logic              in_neg1, in_neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic              is_div_q;
    logic [XLEN:0]     add_a, add_b, sum;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    assign o_ready = (state == S_IDLE);
    assign o_busy  = (state != S_IDLE);
    assign accept  = i_valid && o_ready && !i_flush;

    // Datapath works on magnitudes; the sign of each operand is remembered for the final fixup.
    assign in_neg1 = i_op1[XLEN-1] && (i_op == MDU_MULH || i_op == MDU_MULHSU ||
                                       i_op == MDU_DIV  || i_op == MDU_REM);
    assign in_neg2 = i_op2[XLEN-1] && (i_op == MDU_MULH || i_op == MDU_DIV || i_op == MDU_REM);
    assign mag1    = in_neg1 ? -i_op1 : i_op1;
    assign mag2    = in_neg2 ? -i_op2 : i_op2;

    // Divide by zero and signed overflow bypass the iteration; i_op[1] selects the remainder form.
    assign div_zero    = i_op[2] && (i_op2 == '0);
    assign div_ovf     = (i_op == MDU_DIV || i_op == MDU_REM) && (i_op1 == INT_MIN) && (i_op2 == '1);
    assign special     = div_zero || div_ovf;
    assign special_res = div_zero ? (i_op[1] ? i_op1 : '1) : (i_op[1] ? '0 : i_op1);

    // One XLEN+1-bit adder: add-and-shift for multiply, trial subtract for restoring divide.
    assign is_div_q = op_q[2];
    assign add_a    = is_div_q ? acc[2*XLEN-1:XLEN-1] : {1'b0, acc[2*XLEN-1:XLEN]};
    assign add_b    = is_div_q ? ~{1'b0, opb_q} : (acc[0] ? {1'b0, opb_q} : '0);
    assign sum      = add_a + add_b + {{XLEN{1'b0}}, is_div_q};

    always_comb begin
        acc_step = {sum, acc[XLEN-1:1]};
        if (is_div_q) begin
            if (sum[XLEN])
                acc_step = {acc[2*XLEN-2:0], 1'b0};
            else
                acc_step = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    assign prod = (neg1_q ^ neg2_q) ? -acc : acc;
    assign quo  = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        case (op_q)
            MDU_MUL:                          final_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  final_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                final_res = (neg1_q ^ neg2_q) ? -quo : quo;
            MDU_REM, MDU_REMU:                final_res = neg1_q ? -rem : rem;
            default:                          final_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: if (cnt == '0) state_nxt = S_DONE;
            S_DONE: if (i_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_q     <= MDU_MUL;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            opb_q    <= '0;
            acc      <= '0;
            o_valid  <= 1'b0;
            o_result <= '0;
        end else begin
            state <= state_nxt;
            if (i_flush) begin
                cnt     <= '0;
                o_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_q   <= i_op;
                            neg1_q <= in_neg1;
                            neg2_q <= in_neg2;
                            opb_q  <= mag2;
                            acc    <= {{XLEN{1'b0}}, mag1};
                            if (special) begin
                                o_result <= special_res;
                                o_valid  <= 1'b1;
                                cnt      <= '0;
                            end else begin
                                cnt <= CNT_W'(XLEN);
                            end
                        end
                    end
                    S_CALC: begin
                        // Counter runs XLEN..1 for the steps; the zero cycle applies the sign fixup.
                        if (cnt != '0) begin
                            acc <= acc_step;
                            cnt <= cnt - 1'b1;
                        end else begin
                            o_result <= final_res;
                            o_valid  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (i_ready)
                            o_valid <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_mdu.sv
// tb/tb_ysyx_24090003_mdu.sv - directed self-checking bench for the multiply-divide unit
module tb_ysyx_24090003_mdu;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_op2 = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_24090003_mdu #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(op, a, b);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, o_result, exp);
        consume();
        check({tag, "_rdy"}, {30'd0, o_valid, o_ready}, 32'b01);
    endtask

    initial begin
        int lat;
        int saw_valid;

        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid",  {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_busy",   {31'd0, o_busy}, 32'd0);
        check("rst_ready",  {31'd0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;

        run_op("mul",    3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        run_op("remu",   3'd7, 32'd100, 32'd7, 32'd2, 33);
        run_op("div0",   3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        run_op("remu0",  3'd7, 32'd5, 32'd0, 32'd5, 0);
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 0);

        // DIVU with the result held back for five cycles
        issue(3'd5, 32'd100, 32'd7);
        wait_valid(lat);
        check("divu_lat", 32'(lat), 32'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk);
            #1;
            check("hold_res", o_result, 32'd14);
            check("hold_vr", {30'd0, o_valid, o_ready}, 32'b10);
        end
        consume();
        check("hold_rel", {30'd0, o_valid, o_ready}, 32'b01);

        // flush in the middle of a DIVU
        issue(3'd5, 32'd1000, 32'd3);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush_vr", {29'd0, o_busy, o_valid, o_ready}, 32'b001);
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) saw_valid = 1;
        end
        check("flush_novalid", 32'(saw_valid), 32'd0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // reset in the middle of a MUL; o_result holds 12 beforehand
        issue(3'd0, 32'd9, 32'd9);
        repeat (5) @(posedge i_clk);
        #1;
        check("calc_busy", {31'd0, o_busy}, 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("mrst_valid",  {31'd0, o_valid}, 32'd0);
        check("mrst_result", o_result, 32'd0);
        check("mrst_busy",   {31'd0, o_busy}, 32'd0);
        check("mrst_ready",  {31'd0, o_ready}, 32'd1);
        run_op("mul_after_rst", 3'd0, 32'd9, 32'd9, 32'd81, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
